// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types, default widths and the shift/clamp helper for neuron_mac
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    HOLD   = 2'd3
  } mac_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_WEIGHT_W   = 8;
  localparam int DEF_OUT_W      = 10;
  localparam int DEF_N_INPUTS   = 16;
  localparam int DEF_FRAC_SHIFT = 4;

  typedef struct packed {
    logic signed [63:0] value;
    logic               clamped;
  } sat_res_t;

  // Operates on a 64-bit sign-extended value so one helper serves any width set.
  function automatic sat_res_t sat_shift(input logic signed [63:0] x,
                                         input int shift,
                                         input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t res;
    r  = x >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    res.value   = r;
    res.clamped = 1'b0;
    if (r > hi) begin
      res.value   = hi;
      res.clamped = 1'b1;
    end else if (r < lo) begin
      res.value   = lo;
      res.clamped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// rtl/neuron_mac_if.sv - beat input stream and result handshake bundle for neuron_mac
interface neuron_mac_if import nn_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int N_INPUTS = DEF_N_INPUTS,
  parameter int ACC_W    = DATA_W + WEIGHT_W + $clog2(N_INPUTS) + 1,
  parameter int OUT_W    = DEF_OUT_W
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   in_data;
  logic signed [WEIGHT_W-1:0] in_weight;
  logic                       in_last;
  logic signed [ACC_W-1:0]    bias;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [OUT_W-1:0]    out_data;
  logic                       act_fn_en;
  logic                       overflow;

  modport master (
    output in_valid, in_data, in_weight, in_last, bias, out_ready,
    input  in_ready, out_valid, out_data, act_fn_en, overflow
  );

  modport slave (
    input  in_valid, in_data, in_weight, in_last, bias, out_ready,
    output in_ready, out_valid, out_data, act_fn_en, overflow
  );
endinterface

// File: rtl/mac_sat.sv
// rtl/mac_sat.sv - combinational arithmetic shift and clamp from IN_W down to OUT_W
module mac_sat import nn_pkg::*; #(
  parameter int IN_W       = 22,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic signed [OUT_W-1:0] sat_o,
  output logic                    ovf_o
);
  logic signed [63:0] ext;
  sat_res_t           res;
  logic               unused_hi;

  always_comb begin
    ext = {{(64 - IN_W){val_i[IN_W-1]}}, val_i};
    res = sat_shift(ext, FRAC_SHIFT, OUT_W);
  end

  assign sat_o     = res.value[OUT_W-1:0];
  assign ovf_o     = res.clamped;
  // Clamped value always fits OUT_W; the upper bits are just sign copies.
  assign unused_hi = ^res.value[63:OUT_W];
endmodule

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - signed MAC neuron with shift/saturate output; NEURON_MAC_BIAS_EN enables bias add
module neuron_mac import nn_pkg::*; #(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WEIGHT_W   = DEF_WEIGHT_W,
  parameter int N_INPUTS   = DEF_N_INPUTS,
  parameter int ACC_W      = DATA_W + WEIGHT_W + $clog2(N_INPUTS) + 1,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int OUT_W      = DEF_OUT_W
) (
  input logic         clk,
  input logic         rst,
  neuron_mac_if.slave bus
);
  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int CNT_W  = $clog2(N_INPUTS + 1);

  mac_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    overflow_q, overflow_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W:0]    sum;
  logic signed [OUT_W-1:0]  sat;
  logic                     sat_ovf;
  logic                     in_ready;
  logic                     beat;

  assign prod     = PROD_W'(bus.in_data) * PROD_W'(bus.in_weight);
  assign prod_ext = ACC_W'(prod);

  // One extra bit so acc + bias can never wrap before the shift.
`ifdef NEURON_MAC_BIAS_EN
  assign sum = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(bus.bias);
`else
  logic unused_bias;
  assign sum         = (ACC_W + 1)'(acc_q);
  assign unused_bias = ^bus.bias;
`endif

  mac_sat #(
    .IN_W      (ACC_W + 1),
    .OUT_W     (OUT_W),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_sat (
    .val_i(sum),
    .sat_o(sat),
    .ovf_o(sat_ovf)
  );

  assign in_ready      = (state_q == IDLE) || (state_q == ACCUM);
  assign beat          = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.act_fn_en = (state_q == HOLD) & bus.out_ready;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = overflow_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          state_d = bus.in_last ? FINISH : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.in_last || (cnt_d == CNT_W'(N_INPUTS))) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        out_data_d = sat;
        overflow_d = overflow_q | sat_ovf;
        state_d    = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed self-checking bench for neuron_mac
module tb_neuron_mac;
  localparam int DATA_W     = 8;
  localparam int WEIGHT_W   = 8;
  localparam int N_INPUTS   = 16;
  localparam int ACC_W      = DATA_W + WEIGHT_W + $clog2(N_INPUTS) + 1;
  localparam int FRAC_SHIFT = 4;
  localparam int OUT_W      = 10;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   act_cnt;

  neuron_mac_if #(
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .N_INPUTS(N_INPUTS),
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W)
  ) bus ();

  neuron_mac #(
    .DATA_W    (DATA_W),
    .WEIGHT_W  (WEIGHT_W),
    .N_INPUTS  (N_INPUTS),
    .ACC_W     (ACC_W),
    .FRAC_SHIFT(FRAC_SHIFT),
    .OUT_W     (OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.act_fn_en === 1'b1) act_cnt = act_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int d, input int w, input bit last);
    bus.in_valid  = 1'b1;
    bus.in_data   = DATA_W'(d);
    bus.in_weight = WEIGHT_W'(w);
    bus.in_last   = last;
    tick;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_tests++;
    if (bus.out_data !== 10'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
    n_tests++;
    if (bus.act_fn_en !== 1'b0) begin n_fail++; $display("FAIL reset_act_fn_en: got %b expected 0", bus.act_fn_en); end
    n_tests++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_basic;
    bus.out_ready = 1'b1;
    send_beat(10, 16, 1'b0);
    send_beat(-3, 16, 1'b0);
    send_beat(2, 16, 1'b0);
    send_beat(1, 16, 1'b1);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_finish_in_ready: got %b expected 0", bus.in_ready); end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_finish_out_valid: got %b expected 0", bus.out_valid); end
    tick;
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", bus.out_valid); end
    n_tests++;
    if (bus.act_fn_en !== 1'b1) begin n_fail++; $display("FAIL basic_act_fn_en: got %b expected 1", bus.act_fn_en); end
    n_tests++;
    if (bus.out_data !== 10'sd10) begin n_fail++; $display("FAIL basic_out_data: got %0d expected 10", bus.out_data); end
    n_tests++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b expected 0", bus.overflow); end
    tick;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_forced_end_pos;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(127, 127, 1'b0);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL forced_end_in_ready: got %b expected 0", bus.in_ready); end
    tick;
    n_tests++;
    if (bus.out_data !== 10'sd511) begin n_fail++; $display("FAIL sat_pos_out_data: got %0d expected 511", bus.out_data); end
    n_tests++;
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL sat_pos_overflow: got %b expected 1", bus.overflow); end
    tick;
    send_beat(4, 4, 1'b0);
    send_beat(4, 4, 1'b1);
    tick;
    n_tests++;
    if (bus.out_data !== 10'sd2) begin n_fail++; $display("FAIL sticky_out_data: got %0d expected 2", bus.out_data); end
    n_tests++;
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL sticky_overflow: got %b expected 1", bus.overflow); end
    tick;
  endtask

  task automatic test_sat_neg;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(-128, 127, 1'b0);
    tick;
    n_tests++;
    if (bus.out_data !== -10'sd512) begin n_fail++; $display("FAIL sat_neg_out_data: got %0d expected -512", bus.out_data); end
    n_tests++;
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL sat_neg_overflow: got %b expected 1", bus.overflow); end
    tick;
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = act_cnt;
    bus.out_ready = 1'b0;
    send_beat(3, 16, 1'b0);
    send_beat(3, 16, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'sd5;
    bus.in_weight = 8'sd16;
    bus.in_last   = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 10'sd6 || bus.act_fn_en !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: got in_ready=%b out_valid=%b out_data=%0d act=%b expected 0/1/6/0",
                 i, bus.in_ready, bus.out_valid, bus.out_data, bus.act_fn_en);
      end
      tick;
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.act_fn_en !== 1'b1) begin n_fail++; $display("FAIL release_act_fn_en: got %b expected 1", bus.act_fn_en); end
    tick;
    n_tests++;
    if (act_cnt !== c0 + 1) begin n_fail++; $display("FAIL release_pulse_count: got %0d expected %0d", act_cnt - c0, 1); end
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL next_beat_ready: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    tick;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL next_beat_accepted: got in_ready=%b expected 0", bus.in_ready); end
    tick;
    n_tests++;
    if (bus.out_data !== 10'sd5 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL next_vector_out_data: got %0d valid=%b expected 5/1", bus.out_data, bus.out_valid);
    end
    tick;
    n_tests++;
    if (act_cnt !== c0 + 2) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d expected %0d", act_cnt - c0, 2); end
  endtask

  task automatic test_abort;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(100, 100, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 10'sd0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset_state: got in_ready=%b out_valid=%b out_data=%0d overflow=%b expected 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.overflow);
    end
    send_beat(4, 4, 1'b0);
    send_beat(4, 4, 1'b1);
    tick;
    n_tests++;
    if (bus.out_data !== 10'sd2) begin n_fail++; $display("FAIL abort_fresh_out_data: got %0d expected 2", bus.out_data); end
    n_tests++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL abort_fresh_overflow: got %b expected 0", bus.overflow); end
    tick;
  endtask

  task automatic test_bias;
    int exp_v;
`ifdef NEURON_MAC_BIAS_EN
    exp_v = 0;
`else
    exp_v = 4;
`endif
    bus.out_ready = 1'b1;
    bus.bias      = -21'sd64;
    send_beat(8, 8, 1'b1);
    tick;
    n_tests++;
    if (bus.out_data !== 10'(exp_v)) begin n_fail++; $display("FAIL bias_out_data: got %0d expected %0d", bus.out_data, exp_v); end
    tick;
    bus.bias = '0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    act_cnt       = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_weight = '0;
    bus.in_last   = 1'b0;
    bus.bias      = '0;
    bus.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_forced_end_pos;
    test_sat_neg;
    test_back_to_back;
    test_abort;
    test_bias;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential multiply-accumulate neuron that feeds the activation stage. It consumes a stream of (activation, weight) pairs one per cycle and accumulates their signed products. At end of vector it adds an optional bias, applies a fixed-point shift and saturates to the activation input width. It then presents the pre-activation value with a valid/ready handshake plus a one-cycle `act_fn_en` strobe for the downstream ReLU.

## Interface
- `DATA_W`, 8, signed activation width
- `WEIGHT_W`, 8, signed weight width
- `N_INPUTS`, 16, maximum beats per vector (≥2)
- `ACC_W`, DATA_W+WEIGHT_W+$clog2(N_INPUTS)+1, accumulator width (no internal overflow possible)
- `FRAC_SHIFT`, 4, arithmetic right shift applied before saturation
- `OUT_W`, 10, output width
- `clk` in 1, rising-edge clock
- `rst` in 1, reset; one clock, synchronous, active-high
- `in_valid` in 1, input beat valid
- `in_ready` out 1, block can accept a beat
- `in_data` in DATA_W, signed activation
- `in_weight` in WEIGHT_W, signed weight
- `in_last` in 1, final beat of vector
- `bias` in ACC_W, signed bias, sampled in FINISH
- `out_valid` out 1, result valid
- `out_ready` in 1, consumer accepts result
- `out_data` out OUT_W, signed saturated pre-activation
- `act_fn_en` out 1, one-cycle strobe equal to `out_valid & out_ready`
- `overflow` out 1, sticky: some result was clamped since reset

## Operation
- States are IDLE, ACCUM, FINISH and HOLD.
- A beat is accepted when `in_valid & in_ready`.
- `in_ready`=1 in IDLE and ACCUM, 0 in FINISH and HOLD.
- IDLE: on an accepted beat, acc←product and cnt←1, then go to ACCUM. If that beat has `in_last`, go directly to FINISH.
- ACCUM: on an accepted beat, acc←acc+product and cnt++. Go to FINISH when `in_last`=1 or cnt reaches N_INPUTS (forced end, `in_last` ignored past that). A cycle with no beat holds state.
- Products are full-precision signed DATA_W×WEIGHT_W, sign-extended to ACC_W.
- FINISH: compute r = (acc + bias) >>> FRAC_SHIFT (arithmetic).
  - Clamp r to [−2^(OUT_W−1), 2^(OUT_W−1)−1] and register it into `out_data`.
  - Set `overflow` if clamped.
  - Go to HOLD with `out_valid`=1.
- HOLD: `out_data` is stable while `out_valid`=1. When `out_ready`=1, pulse `act_fn_en`, drop `out_valid`, clear acc and cnt, and go to IDLE.
- A zero-length vector is impossible; the vector starts on its first beat.

## Timing
- Reset values: state=IDLE; `in_ready`=1, `out_valid`=0, `out_data`=0, `act_fn_en`=0, `overflow`=0; acc=0, cnt=0.
- Latency: last beat accepted on edge t, FINISH during cycle t+1, `out_valid`=1 from edge t+2.
- With `out_ready` tied high, `act_fn_en` pulses in cycle t+2.
- Throughput: N beats per vector plus 2 cycles minimum. No new beat is accepted until the cycle after the output handshake.
- `rst` asserted mid-vector or in HOLD aborts the operation. The partial sum is discarded and all outputs return to reset values on the next edge.
- `in_valid` during FINISH or HOLD is not accepted. The upstream source must hold it.

## Configuration
- `NEURON_MAC_BIAS_EN`
  - Defined: `bias` is added in FINISH as above.
  - Undefined: the `bias` port remains but is ignored, so r = acc >>> FRAC_SHIFT. No bias adder is synthesized.

## Structure
- Package `nn_pkg` holds:
  - state enum `mac_state_t` (IDLE, ACCUM, FINISH, HOLD)
  - default width constants (DATA_W, WEIGHT_W, OUT_W)
  - function `sat_shift` (shift plus clamp)
- One sub-module `mac_sat`: combinational shift/clamp from ACC_W to OUT_W, plus an overflow flag.

## Test plan
- Defaults with bias=0, 4 beats (10,16),(−3,16),(2,16),(1,16) and `in_last` on the 4th → acc=160, `out_data`=10, `act_fn_en` in cycle t+2, `overflow`=0.
- 16 beats of (127,127) with no `in_last` → forced end at 16 beats, r=16129 clamped to 511, `overflow`=1 and it stays 1 afterward.
- 16 beats of (−128,127) → `out_data`=−512 and `overflow`=1.
- Result ready, `out_ready` held low for 5 cycles while `in_valid`=1 → `in_ready`=0, `out_data` stable, exactly one `act_fn_en` pulse on release, next beat accepted the following cycle.
- `rst` pulsed after 3 of 6 beats, then a fresh 2-beat vector (4,4),(4,4) → `out_data`=2, with no residue from the aborted vector.
- Bias=−64 with a single beat (8,8) and `in_last`: with `NEURON_MAC_BIAS_EN` → `out_data`=0; without it → `out_data`=4.
